// File: rtl/l2_refill_line_assembler.sv
// Packs L2 return beats into wide refill words and queues them for the L1 refill writer.
// Optional REFILL_OCCUPANCY_EN adds a FIFO occupancy output.
module l2_refill_line_assembler #(
  parameter int unsigned L2_BUS_WIDTH = 64,
  parameter int unsigned BUFFER_WIDTH = 128,
  parameter int unsigned LINE_WORDS   = 4,
  parameter int unsigned FIFO_DEPTH   = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enb_i,
  input  logic                            refill_start_i,
  output logic                            refill_busy_o,
  input  logic [L2_BUS_WIDTH-1:0]         data_from_l2_i,
  input  logic                            data_from_l2_valid_i,
  output logic                            data_from_l2_ready_o,
  output logic [BUFFER_WIDTH-1:0]         refill_data_o,
  output logic                            refill_valid_o,
  input  logic                            refill_ready_i,
  output logic [$clog2(LINE_WORDS)-1:0]   refill_word_idx_o,
`ifdef REFILL_OCCUPANCY_EN
  output logic [$clog2(FIFO_DEPTH):0]     refill_occupancy_o,
`endif
  output logic                            refill_last_o
);

  localparam int unsigned R      = BUFFER_WIDTH / L2_BUS_WIDTH;
  localparam int unsigned BEAT_W = $clog2(R);
  localparam int unsigned IDX_W  = $clog2(LINE_WORDS);
  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned PW     = AW + 1;
  localparam int unsigned HOLD_W = (R - 1) * L2_BUS_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [IDX_W-1:0]    word_q, word_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [PW-1:0]       wr_q, wr_d;
  logic [PW-1:0]       rd_q, rd_d;
  logic [HOLD_W-1:0]   hold_q;
  logic [BUFFER_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic fifo_full, fifo_empty, beat_last, word_last, beat_accept, push, pop;

  assign fifo_empty  = (wr_q == rd_q);
  assign fifo_full   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign beat_last   = (beat_q == BEAT_W'(R - 1));
  assign word_last   = (word_q == IDX_W'(LINE_WORDS - 1));

  // A same-cycle pop never frees a full FIFO: ready looks only at registered state.
  assign data_from_l2_ready_o = enb_i && (state_q == S_FILL) && (!beat_last || !fifo_full);
  assign beat_accept = data_from_l2_valid_i && data_from_l2_ready_o;
  assign push        = beat_accept && beat_last;

  assign refill_valid_o    = enb_i && !fifo_empty;
  assign pop               = refill_valid_o && refill_ready_i;
  assign refill_data_o     = fifo_empty ? '0 : mem_q[rd_q[AW-1:0]];
  assign refill_word_idx_o = idx_q;
  assign refill_last_o     = refill_valid_o && (idx_q == IDX_W'(LINE_WORDS - 1));
  assign refill_busy_o     = (state_q != S_IDLE);
`ifdef REFILL_OCCUPANCY_EN
  assign refill_occupancy_o = wr_q - rd_q;
`endif

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    word_d  = word_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    unique case (state_q)
      S_IDLE: begin
        if (enb_i && refill_start_i) begin
          state_d = S_FILL;
          beat_d  = '0;
          word_d  = '0;
          idx_d   = '0;
        end
      end
      S_FILL:  if (push && word_last) state_d = S_DRAIN;
      S_DRAIN: if (pop && refill_last_o) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (beat_accept) beat_d = beat_last ? '0 : beat_q + BEAT_W'(1);
    if (push) begin
      word_d = word_q + IDX_W'(1);
      wr_d   = wr_q + PW'(1);
    end
    if (pop) begin
      idx_d = idx_q + IDX_W'(1);
      rd_d  = rd_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      word_q  <= '0;
      idx_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  end

  // Data storage carries no reset; validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (beat_accept && !beat_last)
      hold_q[int'(beat_q)*L2_BUS_WIDTH +: L2_BUS_WIDTH] <= data_from_l2_i;
    if (push)
      mem_q[wr_q[AW-1:0]] <= {data_from_l2_i, hold_q};
  end

endmodule

// File: tb/tb_l2_refill_line_assembler.sv
// Scoreboard bench for l2_refill_line_assembler at default parameters (R=2).
module tb_l2_refill_line_assembler;

  localparam int unsigned LBW  = 64;
  localparam int unsigned BW   = 128;
  localparam int unsigned NBT  = 8;

  typedef struct {
    logic [BW-1:0] data;
    logic [1:0]    idx;
    logic          last;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           enb_i;
  logic           refill_start_i;
  logic           refill_busy_o;
  logic [LBW-1:0] data_from_l2_i;
  logic           data_from_l2_valid_i;
  logic           data_from_l2_ready_o;
  logic [BW-1:0]  refill_data_o;
  logic           refill_valid_o;
  logic           refill_ready_i;
  logic [1:0]     refill_word_idx_o;
  logic           refill_last_o;
`ifdef REFILL_OCCUPANCY_EN
  logic [1:0]     refill_occupancy_o;
`endif

  l2_refill_line_assembler dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .enb_i                (enb_i),
    .refill_start_i       (refill_start_i),
    .refill_busy_o        (refill_busy_o),
    .data_from_l2_i       (data_from_l2_i),
    .data_from_l2_valid_i (data_from_l2_valid_i),
    .data_from_l2_ready_o (data_from_l2_ready_o),
    .refill_data_o        (refill_data_o),
    .refill_valid_o       (refill_valid_o),
    .refill_ready_i       (refill_ready_i),
    .refill_word_idx_o    (refill_word_idx_o),
`ifdef REFILL_OCCUPANCY_EN
    .refill_occupancy_o   (refill_occupancy_o),
`endif
    .refill_last_o        (refill_last_o)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  logic        src_en = 1'b0;
  logic        extra_valid = 1'b0;
  int          src_cnt = 0;
  logic [31:0] src_base = 32'h0;
  logic [LBW-1:0] beats [NBT];
  int          occ_m = 0;
  logic        chk_lat = 1'b0;
  logic        chk_idle = 1'b0;
  logic        last_dready, last_valid, line_done;

  task automatic check_eq(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [LBW-1:0] beat_of(input logic [31:0] base, input int k);
    return {base, 32'(k)};
  endfunction

  // One clock: drive source, sample handshakes, update model, advance to posedge+1.
  task automatic tick();
    exp_t e;
    logic acc, popd;
    data_from_l2_valid_i = (src_en && src_cnt < NBT) || extra_valid;
    data_from_l2_i       = (src_cnt < NBT) ? beat_of(src_base, src_cnt) : {LBW{1'b1}};
    #1;
    if (chk_lat && enb_i) check_eq("latency_valid", BW'(refill_valid_o), BW'(1));
    if (chk_idle) check_eq("busy_after_last", BW'(refill_busy_o), BW'(0));
    chk_lat  = 1'b0;
    chk_idle = 1'b0;
`ifdef REFILL_OCCUPANCY_EN
    check_eq("occupancy", BW'(refill_occupancy_o), BW'(occ_m));
`endif
    last_dready = data_from_l2_ready_o;
    last_valid  = refill_valid_o;
    acc  = data_from_l2_valid_i && data_from_l2_ready_o;
    popd = refill_valid_o && refill_ready_i;
    if (popd) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_underflow", BW'(1), BW'(0));
      end else begin
        e = exp_q.pop_front();
        check_eq("word_data", refill_data_o, e.data);
        check_eq("word_idx", BW'(refill_word_idx_o), BW'(e.idx));
        check_eq("word_last", BW'(refill_last_o), BW'(e.last));
        if (e.last) begin
          chk_idle  = 1'b1;
          line_done = 1'b1;
        end
      end
      occ_m--;
    end
    if (acc) begin
      if (extra_valid || src_cnt >= NBT) begin
        check_eq("unexpected_accept", BW'(1), BW'(0));
      end else begin
        beats[src_cnt] = data_from_l2_i;
        if (src_cnt % 2 == 1) begin
          e.data = {beats[src_cnt], beats[src_cnt-1]};
          e.idx  = 2'(src_cnt / 2);
          e.last = (src_cnt / 2 == 3);
          exp_q.push_back(e);
          occ_m++;
          chk_lat = 1'b1;
        end
        src_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic start_line(input logic [31:0] base);
    src_base  = base;
    src_cnt   = 0;
    line_done = 1'b0;
    refill_start_i = 1'b1;
    tick();
    refill_start_i = 1'b0;
    src_en = 1'b1;
  endtask

  task automatic run_until_beats(input int n, input int budget);
    int c = 0;
    while (src_cnt < n && c < budget) begin
      tick();
      c++;
    end
    if (src_cnt < n) check_eq("beat_timeout", BW'(src_cnt), BW'(n));
  endtask

  task automatic finish_line(input int budget);
    int c = 0;
    while (!line_done && c < budget) begin
      tick();
      c++;
    end
    if (!line_done) check_eq("line_timeout", BW'(0), BW'(1));
    tick();
    src_en = 1'b0;
    check_eq("queue_drained", BW'(exp_q.size()), BW'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"},  BW'(refill_busy_o), BW'(0));
    check_eq({tag, "_ready"}, BW'(data_from_l2_ready_o), BW'(0));
    check_eq({tag, "_valid"}, BW'(refill_valid_o), BW'(0));
    check_eq({tag, "_data"},  refill_data_o, BW'(0));
    check_eq({tag, "_idx"},   BW'(refill_word_idx_o), BW'(0));
    check_eq({tag, "_last"},  BW'(refill_last_o), BW'(0));
`ifdef REFILL_OCCUPANCY_EN
    check_eq({tag, "_occ"},   BW'(refill_occupancy_o), BW'(0));
`endif
  endtask

  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    #2;
    check_reset_outputs(tag);
    exp_q.delete();
    occ_m    = 0;
    src_en   = 1'b0;
    chk_lat  = 1'b0;
    chk_idle = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check_eq({tag, "_busy_post"}, BW'(refill_busy_o), BW'(0));
  endtask

  initial begin
    int idx_before;
    rst_n = 1'b0;
    enb_i = 1'b1;
    refill_start_i = 1'b0;
    refill_ready_i = 1'b0;
    data_from_l2_i = '0;
    data_from_l2_valid_i = 1'b0;
    line_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    apply_reset("reset");

    // Clean back-to-back refill
    refill_ready_i = 1'b1;
    start_line(32'h1111_0000);
    check_eq("clean_busy", BW'(refill_busy_o), BW'(1));
    run_until_beats(NBT, 40);
    finish_line(20);

    // Backpressure: FIFO fills after 5 beats
    refill_ready_i = 1'b0;
    start_line(32'h2222_0000);
    run_until_beats(5, 20);
    tick();
    tick();
    check_eq("bp_stuck_cnt", BW'(src_cnt), BW'(5));
    check_eq("bp_ready_low", BW'(last_dready), BW'(0));
    refill_ready_i = 1'b1;
    tick();
    check_eq("bp_pop_no_free", BW'(last_dready), BW'(0));
    refill_ready_i = 1'b0;
    tick();
    check_eq("bp_resume_ready", BW'(last_dready), BW'(1));
    check_eq("bp_resume_cnt", BW'(src_cnt), BW'(6));
    refill_ready_i = 1'b1;
    run_until_beats(NBT, 30);
    finish_line(20);

    // Enable stall mid-fill
    start_line(32'h3333_0000);
    run_until_beats(3, 20);
    idx_before = int'(refill_word_idx_o);
    enb_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_ready", BW'(last_dready), BW'(0));
      check_eq("stall_valid", BW'(last_valid), BW'(0));
      check_eq("stall_cnt", BW'(src_cnt), BW'(3));
      check_eq("stall_idx", BW'(refill_word_idx_o), BW'(idx_before));
      check_eq("stall_busy", BW'(refill_busy_o), BW'(1));
    end
    enb_i = 1'b1;
    run_until_beats(NBT, 30);
    finish_line(20);

    // Reset mid-fill with a queued word, then a fresh line
    refill_ready_i = 1'b0;
    start_line(32'h4444_0000);
    run_until_beats(3, 20);
    apply_reset("rst_mid");
    refill_ready_i = 1'b1;
    start_line(32'h5555_0000);
    run_until_beats(NBT, 40);
    finish_line(20);

    // Protocol edges: beats in IDLE, START in FILL and DRAIN, beats in DRAIN
    src_base = 32'h6666_0000;
    src_cnt  = 0;
    src_en   = 1'b1;
    tick();
    tick();
    check_eq("idle_ready", BW'(last_dready), BW'(0));
    check_eq("idle_no_accept", BW'(src_cnt), BW'(0));
    start_line(32'h6666_0000);
    run_until_beats(3, 20);
    refill_start_i = 1'b1;
    tick();
    refill_start_i = 1'b0;
    check_eq("fill_start_busy", BW'(refill_busy_o), BW'(1));
    run_until_beats(NBT, 30);
    refill_ready_i = 1'b0;
    tick();
    extra_valid = 1'b1;
    refill_start_i = 1'b1;
    tick();
    check_eq("drain_ready", BW'(last_dready), BW'(0));
    extra_valid = 1'b0;
    refill_start_i = 1'b0;
    check_eq("drain_busy", BW'(refill_busy_o), BW'(1));
    check_eq("drain_last", BW'(refill_last_o), BW'(1));
    check_eq("drain_idx", BW'(refill_word_idx_o), BW'(3));
    apply_reset("rst_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
